// File: rtl/demux_pkg.sv
// Shared definitions for the demux routing path: branch-select encoding and
// default sizing used by the route buffer and its per-branch FIFOs.
package demux_pkg;

  // Encoding of the in_sel branch-select bit.
  typedef logic sel_t;
  localparam sel_t SEL_OUT0 = 1'b0;
  localparam sel_t SEL_OUT1 = 1'b1;

  // Default sizing for the routing stage.
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/route_fifo.sv
// Single-clock show-ahead FIFO for one branch of the route buffer.
// Full and empty come from the occupancy counter; pointers wrap modulo DEPTH.
// head_data is forced to zero while the FIFO is empty so idle outputs are clean.
module route_fifo
  import demux_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              valid,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign valid   = (cnt != '0);
  // A full FIFO never accepts, even if a pop happens in the same cycle.
  assign do_push = push && !full;
  // Pops on an empty FIFO are ignored.
  assign do_pop  = pop && valid;

  assign head_data = valid ? mem[rd_ptr] : '0;
  assign count     = cnt;

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; push and pop together keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/demux_route_buffer.sv
// Buffered 1-to-2 steering stage: each incoming word is queued into the FIFO
// named by in_sel, and each FIFO drains independently so a stalled consumer on
// one branch never blocks the other.
//
// Handshakes: a transfer happens on a rising clock edge exactly when valid and
// ready are both high. in_ready depends only on in_sel and registered
// occupancy, never on out*_ready, so no combinational ready path exists.
// outN_valid depends only on registered occupancy.
module demux_route_buffer
  import demux_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [CNT_W-1:0]  count0,
  output logic [CNT_W-1:0]  count1
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;
  logic accept;

  // Ready reflects only the branch currently addressed by in_sel.
  assign in_ready = (in_sel == SEL_OUT1) ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  assign push0    = accept && (in_sel == SEL_OUT0);
  assign push1    = accept && (in_sel == SEL_OUT1);

  route_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .full      (full0),
    .pop       (out0_ready),
    .head_data (out0_data),
    .valid     (out0_valid),
    .count     (count0)
  );

  route_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .full      (full1),
    .pop       (out1_ready),
    .head_data (out1_data),
    .valid     (out1_valid),
    .count     (count1)
  );

endmodule

// File: doc/demux_route_buffer.md
Name: demux_route_buffer

Overview:
- Buffered, handshaked 1-to-2 steering stage for the demultiplexer path.
- Accepts a data word tagged with a select bit and queues it into one of two independent per-output FIFOs.
- Each FIFO drains with its own valid/ready handshake, so a stalled consumer on one branch never blocks traffic to the other.
- Sits between the upstream producer and the two downstream consumers that the demux outputs feed.

Parameters:
- DATA_W, 8, width of the data word.
- DEPTH, 4, entries per output FIFO; must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counters; derived, not overridden.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  stage can accept a word for the branch named by in_sel.
- in_sel  input  1  destination branch: 0 selects FIFO0, 1 selects FIFO1.
- in_data  input  DATA_W  upstream word.
- out0_valid  output  1  FIFO0 non-empty.
- out0_ready  input  1  consumer 0 takes the head word.
- out0_data  output  DATA_W  FIFO0 head word.
- out1_valid  output  1  FIFO1 non-empty.
- out1_ready  input  1  consumer 1 takes the head word.
- out1_data  output  DATA_W  FIFO1 head word.
- count0  output  CNT_W  FIFO0 occupancy, 0..DEPTH.
- count1  output  CNT_W  FIFO1 occupancy, 0..DEPTH.

Behaviour:
- Reset: rst_n low asynchronously clears all pointers and counts.
  - Outputs go to in_ready=1, out*_valid=0, out*_data=0, count*=0.
  - Storage arrays are not reset.
- Reset mid-operation discards all queued words. No output handshake completes in the cycle rst_n deasserts.
- in_ready = !full[in_sel], combinational from in_sel and registered state only.
  - No dependency on out*_ready, so there is no combinational ready path.
- Push: in_valid && in_ready at a rising edge writes in_data to FIFO[in_sel] at its write pointer.
  - The write pointer and count of that FIFO advance.
  - The other FIFO is untouched.
- Pop: outN_valid && outN_ready at a rising edge advances FIFO N's read pointer and decrements its count.
- outN_valid = (countN != 0).
- outN_data = head entry when outN_valid, else 0 (show-ahead, no extra read latency).
- Latency: a word accepted at edge k is visible at the output from edge k onward (valid in cycle k+1).
  - There is no same-cycle bypass from an empty FIFO.
- Simultaneous push and pop on the same FIFO:
  - The count is unchanged and both pointers advance.
  - Legal at any occupancy except full; a full FIFO never accepts, even with a concurrent pop.
- Full (count=DEPTH): in_ready is 0 whenever in_sel points at that FIFO. The producer holds in_data and in_sel stable until accepted.
- Changing in_sel while in_valid is high and unaccepted is a protocol violation. The block behaves per the current in_sel and raises no error.
- Empty (count=0): outN_valid=0; outN_ready is ignored and causes no pointer change.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- Full and empty are derived from count, not from pointer comparison.
- Ordering: strict FIFO order within a branch. There is no ordering relation between branches.
- No state machine beyond the per-FIFO pointer/count registers. No combinational loops.

Decomposition:
- Shared package demux_pkg holds:
  - the branch-select encoding constants (SEL_OUT0=1'b0, SEL_OUT1=1'b1);
  - the default DATA_W and DEPTH localparams.
- One natural sub-module, route_fifo: a single-clock show-ahead FIFO with parameters DATA_W and DEPTH.
  - Ports: clk, rst_n, push, push_data, full, pop, head_data, valid, count.
- The top instantiates route_fifo twice and adds the steering logic:
  - push enable per branch;
  - in_ready mux on in_sel.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 words in FIFO0 -> immediately count0=0, out0_valid=0, out0_data=0, in_ready=1. After release, no stale word appears.
- Steering: push 0x11 (sel 0), 0x22 (sel 1), 0x33 (sel 0) with both readies low -> count0=2, count1=1. out0_data=0x11, out1_data=0x22.
- Order and drain: with out0_ready=1, FIFO0 emits 0x11 then 0x33 on consecutive cycles. out0_valid drops the cycle after the last pop.
- Full isolation: DEPTH=4, fill FIFO1 with 0xA0..0xA3 and out1_ready=0.
  - sel=1 gives in_ready=0 and a 5th word is not taken.
  - Switching to sel=0 gives in_ready=1 and 0xB0 lands in FIFO0.
- Full with concurrent pop: FIFO0 full, out0_ready=1, in_valid=1, sel=0 -> in_ready=0. One pop leaves count0=3, and the word is accepted the next cycle.
- Wrap and concurrency: 20 random words to each branch with random ready patterns, including same-cycle push and pop at count=2.
  - Each branch output must match its scoreboard queue exactly.
  - count must never exceed 4 or underflow.
